// File: rtl/led_fade_driver.sv
// led_fade_driver: per-LED PWM whose duty ramps toward brightness (on) or 0 (off).
// Optional LED_FADE_INSTANT_ON_EN: a lit LED below brightness jumps straight to it.
module led_fade_driver #(
  parameter int N_LEDS    = 8,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 1024,
  parameter int FADE_STEP = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_LEDS-1:0]   led_in,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   led_out,
  output logic                busy
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(FADE_STEP);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PW-1:0] presc_cnt;
  logic [N_LEDS-1:0][PWM_BITS-1:0] level, level_nx;
  logic [N_LEDS-1:0] diff, pwm_on, jump;
  logic tick;
  assign tick = enable && presc_cnt == PRESC_MAX;
  // one extra bit keeps the step arithmetic free of wrap-around
  for (genvar i = 0; i < N_LEDS; i++) begin : g_led
    logic [PWM_BITS:0] lv, tg, up, dn, nx;
    assign lv = {1'b0, level[i]};
    assign tg = {1'b0, led_in[i] ? brightness : {PWM_BITS{1'b0}}};
    assign up = (tg - lv > STEP) ? lv + STEP : tg;
    assign dn = (lv - tg > STEP) ? lv - STEP : tg;
    assign nx = tg > lv ? up : lv > tg ? dn : lv;
    assign level_nx[i] = nx[PWM_BITS-1:0];
    assign diff[i] = lv != tg;
    assign pwm_on[i] = pwm_cnt < level[i];
`ifdef LED_FADE_INSTANT_ON_EN
    assign jump[i] = enable && led_in[i] && level[i] < brightness;
`else
    assign jump[i] = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt   <= '0;
      presc_cnt <= '0;
      level     <= '0;
      led_out   <= '0;
      busy      <= 1'b0;
    end else begin
      if (enable) begin
        pwm_cnt   <= pwm_cnt == PWM_MAX ? '0 : pwm_cnt + 1'b1;
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      end
      for (int i = 0; i < N_LEDS; i++)
        level[i] <= jump[i] ? brightness : tick ? level_nx[i] : level[i];
      led_out <= enable ? pwm_on : '0;
      busy    <= |diff;
    end
  end
endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: vector table, corner sequences and random stimulus vs. a cycle model.
module tb_led_fade_driver;
  localparam int N = 8;
  localparam int STEP = 64;
  localparam int PRESC = 4;
  logic clk = 0;
  logic reset = 1;
  logic [N-1:0] led_in = '0;
  logic enable = 0;
  logic [7:0] brightness = '0;
  logic [N-1:0] led_out;
  logic busy;
  int checks = 0;
  int errors = 0;
  int m_level[N];
  int m_pwm, m_presc;
  logic [N-1:0] m_out;
  logic m_busy;
  led_fade_driver #(.N_LEDS(N), .PWM_BITS(8), .PRESCALE(PRESC), .FADE_STEP(STEP)) u_dut (
    .clk(clk), .reset(reset), .led_in(led_in), .enable(enable),
    .brightness(brightness), .led_out(led_out), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // advance one clock; the model follows the behavioural rules with plain integers
  task automatic cyc();
    int nl[N];
    int np, nps, tgt;
    logic [N-1:0] n_out;
    logic nb;
    if (reset) begin
      foreach (nl[i]) nl[i] = 0;
      np = 0; nps = 0; n_out = '0; nb = 0;
    end else begin
      nb = 0;
      for (int i = 0; i < N; i++) begin
        tgt = led_in[i] ? int'(brightness) : 0;
        nl[i] = m_level[i];
        if (enable && m_presc == PRESC - 1)
          nl[i] = m_level[i] < tgt ? ((m_level[i] + STEP < tgt) ? m_level[i] + STEP : tgt)
                                   : ((m_level[i] - STEP > tgt) ? m_level[i] - STEP : tgt);
`ifdef LED_FADE_INSTANT_ON_EN
        if (enable && led_in[i] && m_level[i] < int'(brightness)) nl[i] = brightness;
`endif
        if (m_level[i] != tgt) nb = 1;
        n_out[i] = enable && m_pwm < m_level[i];
      end
      np = enable ? (m_pwm + 1) % 255 : m_pwm;
      nps = enable ? (m_presc + 1) % PRESC : m_presc;
    end
    @(posedge clk);
    #1;
    m_level = nl; m_pwm = np; m_presc = nps; m_out = n_out; m_busy = nb;
    chk("led_out", led_out, m_out);
    chk("busy", busy, m_busy);
    for (int i = 0; i < N; i++) chk($sformatf("level%0d", i), u_dut.level[i], m_level[i]);
  endtask
  task automatic do_reset();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask
  task automatic wait_level(int led, int val, int bound);
    int n = 0;
    while (m_level[led] != val && n < bound) begin cyc(); n++; end
    chk("wait_level", m_level[led], val);
  endtask
  task automatic wait_change(int led, int bound);
    int v = m_level[led];
    int n = 0;
    while (m_level[led] == v && n < bound) begin cyc(); n++; end
    chk("wait_change", n < bound, 1);
  endtask
  typedef struct {
    logic [7:0] led;
    logic [7:0] br;
    int n;
    int lvl0;
    logic bz;
  } vec_t;
  vec_t tbl[10];
  initial begin
    int hi, lo, saved_lvl, saved_presc;
    do_reset();
    chk("reset_led_out", led_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_presc", u_dut.presc_cnt, 0);
`ifndef LED_FADE_INSTANT_ON_EN
    tbl[0] = '{8'h01, 8'd255, 4, 64, 1};
    tbl[1] = '{8'h01, 8'd255, 4, 128, 1};
    tbl[2] = '{8'h01, 8'd255, 4, 192, 1};
    tbl[3] = '{8'h01, 8'd255, 4, 255, 1};
    tbl[4] = '{8'h01, 8'd255, 1, 255, 0};
    tbl[5] = '{8'h00, 8'd255, 3, 191, 1};
    tbl[6] = '{8'h00, 8'd255, 4, 127, 1};
    tbl[7] = '{8'h00, 8'd255, 4, 63, 1};
    tbl[8] = '{8'h00, 8'd255, 4, 0, 1};
    tbl[9] = '{8'h00, 8'd255, 1, 0, 0};
    enable = 1;
    foreach (tbl[r]) begin
      led_in = tbl[r].led;
      brightness = tbl[r].br;
      repeat (tbl[r].n) cyc();
      chk($sformatf("tbl%0d_lvl0", r), u_dut.level[0], tbl[r].lvl0);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bz);
    end
    // half duty: level 128 lights 128 of every 255 clocks
    do_reset();
    brightness = 128; led_in = 8'h80;
    wait_level(7, 128, 50);
    hi = 0; lo = 0;
    repeat (255) begin
      cyc();
      hi += led_out[7];
      lo += led_out[0];
    end
    chk("duty128", hi, 128);
    chk("led0_dark", lo, 0);
    // retarget mid-fade, then a short pulse between ticks
    do_reset();
    brightness = 255; led_in = 8'h01;
    wait_level(0, 128, 50);
    brightness = 64;
    wait_change(0, 8);
    chk("retarget", u_dut.level[0], 64);
    repeat (8) cyc();
    chk("retarget_hold", u_dut.level[0], 64);
    chk("retarget_idle", busy, 0);
    led_in = 8'h03;
    cyc();
    led_in = 8'h01;
    repeat (6) cyc();
    chk("glitch_ignored", u_dut.level[1], 0);
    // freeze mid-fade, resume, then reset mid-fade
    do_reset();
    brightness = 255; led_in = 8'h01;
    wait_level(0, 128, 50);
    cyc();
    saved_lvl = m_level[0];
    saved_presc = m_presc;
    enable = 0;
    cyc();
    chk("freeze_blank", led_out, 0);
    repeat (19) cyc();
    chk("freeze_level", u_dut.level[0], saved_lvl);
    chk("freeze_presc", u_dut.presc_cnt, saved_presc);
    chk("freeze_busy", busy, 1);
    enable = 1;
    repeat (12) cyc();
    chk("resume_level", u_dut.level[0], 255);
    led_in = 8'h00;
    repeat (5) cyc();
    reset = 1;
    cyc();
    chk("midreset_out", led_out, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_level", u_dut.level[0], 0);
    reset = 0;
`else
    begin
      int downs[4] = '{136, 72, 8, 0};
      enable = 1; brightness = 200; led_in = 8'h00;
      cyc();
      cyc();
      led_in = 8'h0F;
      cyc();
      for (int i = 0; i < 4; i++) chk($sformatf("instant%0d", i), u_dut.level[i], 200);
      chk("instant_upper", u_dut.level[4], 0);
      led_in = 8'h00;
      for (int k = 0; k < 4; k++) begin
        wait_change(0, 8);
        chk($sformatf("ramp_down%0d", k), u_dut.level[0], downs[k]);
      end
    end
`endif
    // random traffic against the model
    do_reset();
    enable = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 20) led_in = N'($urandom);
      if ($urandom_range(99) < 5) brightness = 8'($urandom);
      if ($urandom_range(99) < 4) enable = ~enable;
      reset = $urandom_range(999) < 5;
      cyc();
    end
    reset = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
